bus_protocol_arbiter: RTL

- Shares a single bus_protocol manager port (the AHB-Lite manager bridge) between NREQ requesters, e.g. the JTAG debug transport and the core data port.
- Round-robin, non-preemptive arbitration: a grant is held from acceptance until the transaction completes.
- Forwards the owner's request to the manager; returns stall, read data and error only to the owner.
- Sits directly upstream of the AHB manager bridge, on the same clock.

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/bus_protocol_arbiter_rr_picker.sv | 25 ++
 rtl/bus_protocol_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and the round-robin search used by the bus arbiter and its picker.
package bus_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int MAX_REQ = 8;

  // First set bit of pending, scanning last+1, last+2, ... modulo n; -1 when none.
  function automatic int rr_next(input logic [MAX_REQ-1:0] pending, input int last, input int n);
    int idx;
    rr_next = -1;
    for (int k = 1; k <= n; k++) begin
      idx = (last + k) % n;
      if (rr_next < 0 && pending[idx[2:0]]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/bus_protocol_arbiter_rr_picker.sv
// Combinational round-robin priority encoder; the requester after `last` wins first.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [MAX_REQ-1:0] pend_ext;
  int                 w;

  always_comb begin
    pend_ext              = '0;
    pend_ext[NREQ-1:0]    = pending;
    w                     = rr_next(pend_ext, int'(last), NREQ);
    any                   = (w >= 0);
    winner                = any ? IW'(w) : '0;
  end

endmodule

// File: rtl/bus_protocol_arbiter.sv
// Non-preemptive round-robin share of one bus manager port between NREQ requesters;
// one IDLE arbitration cycle precedes every grant.
module bus_protocol_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32,
  localparam int SW  = DW / 8,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*SW-1:0]   req_strobe,
  output logic [NREQ*DW-1:0]   req_rdata,
  output logic [NREQ-1:0]      req_error,
  output logic [NREQ-1:0]      req_stall,
  output logic                 mgr_ren,
  output logic                 mgr_wen,
  output logic [AW-1:0]        mgr_addr,
  output logic [DW-1:0]        mgr_wdata,
  output logic [SW-1:0]        mgr_strobe,
  input  logic [DW-1:0]        mgr_rdata,
  input  logic                 mgr_error,
  input  logic                 mgr_request_stall,
  output logic [IW-1:0]        grant_id,
  output logic                 busy
);

  state_t                    state_q, state_d;
  logic [IW-1:0]             owner_q, owner_d;
  logic [IW-1:0]             last_q, last_d;
  logic [IW-1:0]             winner;
  logic                      any_pending;
  logic [NREQ-1:0]           pending;

  logic [NREQ-1:0][AW-1:0]   addr_a;
  logic [NREQ-1:0][DW-1:0]   wdata_a;
  logic [NREQ-1:0][SW-1:0]   strobe_a;
  logic [NREQ-1:0][DW-1:0]   rdata_a;

  assign addr_a    = req_addr;
  assign wdata_a   = req_wdata;
  assign strobe_a  = req_strobe;
  assign req_rdata = rdata_a;
  assign pending   = req_ren | req_wen;
  assign busy      = (state_q == BUSY);
  assign grant_id  = owner_q;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .pending (pending),
    .last    (last_q),
    .winner  (winner),
    .any     (any_pending)
  );

  // Return path: only the owning slice sees the manager's response.
  for (genvar i = 0; i < NREQ; i++) begin : g_ret
    logic sel;
    assign sel        = busy && (owner_q == IW'(i));
    assign req_stall[i] = sel ? mgr_request_stall : 1'b1;
    assign req_error[i] = sel & mgr_error;
    assign rdata_a[i]   = sel ? mgr_rdata : '0;
  end

  always_comb begin
    mgr_ren    = 1'b0;
    mgr_wen    = 1'b0;
    mgr_addr   = '0;
    mgr_wdata  = '0;
    mgr_strobe = '0;
    if (busy) begin
      mgr_ren    = req_ren[owner_q];
      mgr_wen    = req_wen[owner_q];
      mgr_addr   = addr_a[owner_q];
      mgr_wdata  = wdata_a[owner_q];
      mgr_strobe = strobe_a[owner_q];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (any_pending) begin
        state_d = BUSY;
        owner_d = winner;
      end
      BUSY: begin
        // Completion or a dropped request both release the grant and rotate priority.
        if (!mgr_request_stall || !pending[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule
